// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper: PS/2 key map, joystick bit
// layout and the key-map entry type.
package arcade_input_pkg;

   localparam int JOY_R     = 0;
   localparam int JOY_L     = 1;
   localparam int JOY_D     = 2;
   localparam int JOY_U     = 3;
   localparam int JOY_BTN0  = 4;
   localparam int JOY_FIXED = 6;

   typedef enum logic [1:0] {
      KIND_DIR,
      KIND_BTN,
      KIND_START,
      KIND_COIN
   } key_kind_e;

   typedef struct packed {
      logic      valid;
      logic      player;
      key_kind_e kind;
      logic [1:0] index;
   } key_map_t;

   function automatic key_map_t mapEntry(input logic player, input key_kind_e kind,
                                         input logic [1:0] index);
      key_map_t m;
      m.valid  = 1'b1;
      m.player = player;
      m.kind   = kind;
      m.index  = index;
      return m;
   endfunction

   // Direction entries use the joystick bit position as their index.
   function automatic key_map_t lookupKey(input logic ext, input logic [7:0] code);
      key_map_t m;
      m = '0;
      case ({ext, code})
         9'h175: m = mapEntry(1'b0, KIND_DIR, 2'(JOY_U));
         9'h172: m = mapEntry(1'b0, KIND_DIR, 2'(JOY_D));
         9'h16B: m = mapEntry(1'b0, KIND_DIR, 2'(JOY_L));
         9'h174: m = mapEntry(1'b0, KIND_DIR, 2'(JOY_R));
         9'h014: m = mapEntry(1'b0, KIND_BTN, 2'd0);
         9'h029: m = mapEntry(1'b0, KIND_BTN, 2'd1);
         9'h012: m = mapEntry(1'b0, KIND_BTN, 2'd2);
         9'h01A: m = mapEntry(1'b0, KIND_BTN, 2'd3);
         9'h02D: m = mapEntry(1'b1, KIND_DIR, 2'(JOY_U));
         9'h02B: m = mapEntry(1'b1, KIND_DIR, 2'(JOY_D));
         9'h023: m = mapEntry(1'b1, KIND_DIR, 2'(JOY_L));
         9'h034: m = mapEntry(1'b1, KIND_DIR, 2'(JOY_R));
         9'h01C: m = mapEntry(1'b1, KIND_BTN, 2'd0);
         9'h01B: m = mapEntry(1'b1, KIND_BTN, 2'd1);
         9'h015: m = mapEntry(1'b1, KIND_BTN, 2'd2);
         9'h01D: m = mapEntry(1'b1, KIND_BTN, 2'd3);
         9'h005: m = mapEntry(1'b0, KIND_START, 2'd0);
         9'h006: m = mapEntry(1'b1, KIND_START, 2'd0);
         9'h004: m = mapEntry(1'b0, KIND_COIN, 2'd0);
         9'h00C: m = mapEntry(1'b1, KIND_COIN, 2'd0);
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// Turns a coin request into a single fixed-width active-low pulse; a new pulse
// needs the request to rise again after the current one has finished.
module coin_pulser #(
   parameter int COIN_PULSE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   output logic coin_n_o
);

   localparam int CNTW = $clog2(COIN_PULSE + 1);

   logic            reqPrev_q;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            active_q, active_d;

   // Rising edges are only honoured while no pulse is counting down.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - CNTW'(1);
      end else if (req_i && !reqPrev_q) begin
         cnt_d = CNTW'(COIN_PULSE);
      end
      active_d = (cnt_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reqPrev_q <= 1'b0;
         cnt_q     <= '0;
         active_q  <= 1'b0;
      end else begin
         reqPrev_q <= req_i;
         cnt_q     <= cnt_d;
         active_q  <= active_d;
      end
   end

   assign coin_n_o = ~active_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keyboard players with joystick players, applies SOCD cleaning,
// autofire and coin pulse shaping, and drives active-low control buses.
module arcade_input_mapper
   import arcade_input_pkg::*;
#(
   parameter int NUM_PLAYERS  = 2,
   parameter int NUM_BTN      = 2,
   parameter int COIN_PULSE   = 16,
   parameter int AUTOFIRE_DIV = 65536,
   parameter int SOCD_NEUTRAL = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [10:0]                           ps2_key,
   input  logic                                  key_clear,
   input  logic [NUM_PLAYERS*(6+NUM_BTN)-1:0]    joy_in,
   input  logic [NUM_PLAYERS*NUM_BTN-1:0]        autofire_en,
   output logic [NUM_PLAYERS*(4+NUM_BTN)-1:0]    ctrl_n,
   output logic [NUM_PLAYERS-1:0]                start_n,
   output logic [NUM_PLAYERS-1:0]                coin_n
);

   localparam int JW  = JOY_FIXED + NUM_BTN;
   localparam int CW  = 4 + NUM_BTN;
   localparam int AFW = $clog2(AUTOFIRE_DIV);

   logic                      toggle_q;
   logic [1:0][3:0]           keyDir_q, keyDir_d;
   logic [1:0][NUM_BTN-1:0]   keyBtn_q, keyBtn_d;
   logic [1:0]                keyStart_q, keyStart_d;
   logic [1:0]                keyCoin_q, keyCoin_d;
   logic [AFW-1:0]            afCnt_q, afCnt_d;
   logic                      phase_q, phase_d;
   logic [NUM_PLAYERS*CW-1:0] ctrlN_q, ctrlN_d;
   logic [NUM_PLAYERS-1:0]    startN_q, startN_d;
   logic [NUM_PLAYERS-1:0]    coinReq;
   key_map_t                  hit;
   logic                      keyEvent;

   // A PS/2 event is a flip of the toggle bit; key_clear overrides any event.
   always_comb begin
      hit        = lookupKey(ps2_key[8], ps2_key[7:0]);
      keyEvent   = (ps2_key[10] != toggle_q);
      keyDir_d   = keyDir_q;
      keyBtn_d   = keyBtn_q;
      keyStart_d = keyStart_q;
      keyCoin_d  = keyCoin_q;
      if (key_clear) begin
         keyDir_d   = '0;
         keyBtn_d   = '0;
         keyStart_d = '0;
         keyCoin_d  = '0;
      end else if (keyEvent && hit.valid && (int'(hit.player) < NUM_PLAYERS)) begin
         case (hit.kind)
            KIND_DIR:   keyDir_d[hit.player][hit.index] = ps2_key[9];
            KIND_BTN: begin
               for (int b = 0; b < NUM_BTN; b++) begin
                  if (hit.index == 2'(b)) keyBtn_d[hit.player][b] = ps2_key[9];
               end
            end
            KIND_START: keyStart_d[hit.player] = ps2_key[9];
            default:    keyCoin_d[hit.player] = ps2_key[9];
         endcase
      end
   end

   always_comb begin
      if (afCnt_q == AFW'(AUTOFIRE_DIV - 1)) begin
         afCnt_d = '0;
         phase_d = ~phase_q;
      end else begin
         afCnt_d = afCnt_q + AFW'(1);
         phase_d = phase_q;
      end
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : gPlayer
      logic [3:0]         kbDir, dirReq, dirClean;
      logic [NUM_BTN-1:0] kbBtn, btnReq, btnOut;
      logic               kbStart, kbCoin;

      // Only the first two players have a keyboard map.
      if (p < 2) begin : gKbd
         assign kbDir   = keyDir_q[p];
         assign kbBtn   = keyBtn_q[p];
         assign kbStart = keyStart_q[p];
         assign kbCoin  = keyCoin_q[p];
      end else begin : gNoKbd
         assign kbDir   = '0;
         assign kbBtn   = '0;
         assign kbStart = 1'b0;
         assign kbCoin  = 1'b0;
      end

      assign dirReq = joy_in[p*JW +: 4] | kbDir;
      assign btnReq = joy_in[p*JW+JOY_BTN0 +: NUM_BTN] | kbBtn;

      always_comb begin
         dirClean = dirReq;
         if (SOCD_NEUTRAL != 0) begin
            if (dirReq[JOY_R] && dirReq[JOY_L]) begin
               dirClean[JOY_R] = 1'b0;
               dirClean[JOY_L] = 1'b0;
            end
            if (dirReq[JOY_U] && dirReq[JOY_D]) begin
               dirClean[JOY_U] = 1'b0;
               dirClean[JOY_D] = 1'b0;
            end
         end
      end

      assign btnOut  = btnReq & (~autofire_en[p*NUM_BTN +: NUM_BTN] | {NUM_BTN{phase_q}});
      assign ctrlN_d[p*CW +: CW] = ~{btnOut, dirClean};
      assign startN_d[p] = ~(joy_in[p*JW+JOY_BTN0+NUM_BTN] | kbStart);
      assign coinReq[p]  = joy_in[p*JW+JOY_BTN0+NUM_BTN+1] | kbCoin;

      coin_pulser #(
         .COIN_PULSE(COIN_PULSE)
      ) uCoin (
         .clk     (clk),
         .rst     (rst),
         .req_i   (coinReq[p]),
         .coin_n_o(coin_n[p])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         toggle_q   <= 1'b0;
         keyDir_q   <= '0;
         keyBtn_q   <= '0;
         keyStart_q <= '0;
         keyCoin_q  <= '0;
         afCnt_q    <= '0;
         phase_q    <= 1'b0;
         ctrlN_q    <= '1;
         startN_q   <= '1;
      end else begin
         toggle_q   <= ps2_key[10];
         keyDir_q   <= keyDir_d;
         keyBtn_q   <= keyBtn_d;
         keyStart_q <= keyStart_d;
         keyCoin_q  <= keyCoin_d;
         afCnt_q    <= afCnt_d;
         phase_q    <= phase_d;
         ctrlN_q    <= ctrlN_d;
         startN_q   <= startN_d;
      end
   end

   assign ctrl_n  = ctrlN_q;
   assign start_n = startN_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper: a cycle-level behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_arcade_input_mapper;

   localparam int NP = 2;
   localparam int NB = 2;
   localparam int CP = 8;
   localparam int AD = 4;
   localparam int JW = 6 + NB;
   localparam int CW = 4 + NB;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [10:0]     ps2_key = '0;
   logic            key_clear = 1'b0;
   logic [NP*JW-1:0] joy_in = '0;
   logic [NP*NB-1:0] autofire_en = '0;
   logic [NP*CW-1:0] ctrl_n;
   logic [NP-1:0]   start_n;
   logic [NP-1:0]   coin_n;

   int  checks = 0;
   int  errors = 0;
   bit  checking = 1'b0;
   bit  txToggle = 1'b0;
   int  coinLows = 0;
   int  coinFalls = 0;
   bit  coinPrev = 1'b1;

   int  edgeCount;
   bit  togglePrev;
   bit  kDir[NP][4];
   bit  kBtn[NP][NB];
   bit  kStart[NP];
   bit  kCoin[NP];
   bit  prevCoin[NP];
   int  pulseEnd[NP];
   logic [NP*CW-1:0] expCtrl;
   logic [NP-1:0]    expStart;
   logic [NP-1:0]    expCoin;

   arcade_input_mapper #(
      .NUM_PLAYERS (NP),
      .NUM_BTN     (NB),
      .COIN_PULSE  (CP),
      .AUTOFIRE_DIV(AD),
      .SOCD_NEUTRAL(1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_key    (ps2_key),
      .key_clear  (key_clear),
      .joy_in     (joy_in),
      .autofire_en(autofire_en),
      .ctrl_n     (ctrl_n),
      .start_n    (start_n),
      .coin_n     (coin_n)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic void clearKeys();
      for (int p = 0; p < NP; p++) begin
         for (int i = 0; i < 4; i++) kDir[p][i] = 1'b0;
         for (int b = 0; b < NB; b++) kBtn[p][b] = 1'b0;
         kStart[p] = 1'b0;
         kCoin[p]  = 1'b0;
      end
   endfunction

   function automatic void resetModel();
      clearKeys();
      edgeCount  = 0;
      togglePrev = 1'b0;
      for (int p = 0; p < NP; p++) begin
         prevCoin[p] = 1'b0;
         pulseEnd[p] = 0;
      end
      expCtrl  = '1;
      expStart = '1;
      expCoin  = '1;
   endfunction

   // Key map as a table of (player, kind, index); kind 0 dir, 1 btn, 2 start, 3 coin.
   function automatic void modelKeyEvent(input bit pressed, input bit ext, input logic [7:0] code);
      int pl, kind, idx;
      bit known;
      known = 1'b1;
      pl = 0; kind = 0; idx = 0;
      case ({ext, code})
         9'h175: begin pl = 0; kind = 0; idx = 3; end
         9'h172: begin pl = 0; kind = 0; idx = 2; end
         9'h16B: begin pl = 0; kind = 0; idx = 1; end
         9'h174: begin pl = 0; kind = 0; idx = 0; end
         9'h014: begin pl = 0; kind = 1; idx = 0; end
         9'h029: begin pl = 0; kind = 1; idx = 1; end
         9'h012: begin pl = 0; kind = 1; idx = 2; end
         9'h01A: begin pl = 0; kind = 1; idx = 3; end
         9'h02D: begin pl = 1; kind = 0; idx = 3; end
         9'h02B: begin pl = 1; kind = 0; idx = 2; end
         9'h023: begin pl = 1; kind = 0; idx = 1; end
         9'h034: begin pl = 1; kind = 0; idx = 0; end
         9'h01C: begin pl = 1; kind = 1; idx = 0; end
         9'h01B: begin pl = 1; kind = 1; idx = 1; end
         9'h015: begin pl = 1; kind = 1; idx = 2; end
         9'h01D: begin pl = 1; kind = 1; idx = 3; end
         9'h005: begin pl = 0; kind = 2; end
         9'h006: begin pl = 1; kind = 2; end
         9'h004: begin pl = 0; kind = 3; end
         9'h00C: begin pl = 1; kind = 3; end
         default: known = 1'b0;
      endcase
      if (known && pl < NP) begin
         if (kind == 0) kDir[pl][idx] = pressed;
         else if (kind == 1 && idx < NB) kBtn[pl][idx] = pressed;
         else if (kind == 2) kStart[pl] = pressed;
         else if (kind == 3) kCoin[pl] = pressed;
      end
   endfunction

   // Outputs after an edge come from inputs at that edge and keys latched before it.
   function automatic void modelEdge();
      bit phase, req, c;
      bit d[4];
      phase = ((edgeCount / AD) % 2) == 1;
      for (int p = 0; p < NP; p++) begin
         for (int i = 0; i < 4; i++) d[i] = joy_in[p*JW+i] | kDir[p][i];
         if (d[0] && d[1]) begin d[0] = 1'b0; d[1] = 1'b0; end
         if (d[2] && d[3]) begin d[2] = 1'b0; d[3] = 1'b0; end
         for (int i = 0; i < 4; i++) expCtrl[p*CW+i] = !d[i];
         for (int b = 0; b < NB; b++) begin
            req = joy_in[p*JW+4+b] | kBtn[p][b];
            expCtrl[p*CW+4+b] = !(req && (!autofire_en[p*NB+b] || phase));
         end
         expStart[p] = !(joy_in[p*JW+4+NB] | kStart[p]);
         c = joy_in[p*JW+5+NB] | kCoin[p];
         if (c && !prevCoin[p] && expCoin[p]) pulseEnd[p] = edgeCount + CP;
         prevCoin[p] = c;
         expCoin[p] = !(edgeCount < pulseEnd[p]);
      end
      if (key_clear) clearKeys();
      else if (ps2_key[10] != togglePrev) modelKeyEvent(ps2_key[9], ps2_key[8], ps2_key[7:0]);
      togglePrev = ps2_key[10];
      edgeCount++;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) resetModel();
      else modelEdge();
   end

   always @(negedge clk) begin
      if (checking) begin
         checkOutput("model ctrl_n", 32'(ctrl_n), 32'(expCtrl));
         checkOutput("model start_n", 32'(start_n), 32'(expStart));
         checkOutput("model coin_n", 32'(coin_n), 32'(expCoin));
      end
      if (!coin_n[0]) coinLows++;
      if (coinPrev && !coin_n[0]) coinFalls++;
      coinPrev = coin_n[0];
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendKey(input bit pressed, input bit ext, input logic [7:0] code);
      txToggle = !txToggle;
      ps2_key  = {txToggle, pressed, ext, code};
   endtask

   task automatic applyStimulus();
      logic [8:0] codes[23] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h014, 9'h029, 9'h012,
                                9'h01A, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h01B,
                                9'h015, 9'h01D, 9'h005, 9'h006, 9'h004, 9'h00C, 9'h075,
                                9'h1AA, 9'h033};
      logic [8:0] pick;
      if ($urandom_range(0, 2) == 0) joy_in[$urandom_range(0, NP*JW-1)] ^= 1'b1;
      if ($urandom_range(0, 19) == 0) autofire_en = (NP*NB)'($urandom_range(0, (1 << (NP*NB)) - 1));
      if ($urandom_range(0, 3) == 0) begin
         pick = codes[$urandom_range(0, 22)];
         sendKey(1'($urandom_range(0, 1)), pick[8], pick[7:0]);
      end
      key_clear = ($urandom_range(0, 49) == 0);
   endtask

   initial begin
      int l0, f0;
      bit s[16];
      bit altOk, allLow, found;
      int trans;

      resetModel();
      step(2);
      rst = 1'b0;
      checking = 1'b1;
      checkOutput("reset ctrl_n", 32'(ctrl_n), 32'h0FFF);
      checkOutput("reset start_n", 32'(start_n), 32'h3);
      checkOutput("reset coin_n", 32'(coin_n), 32'h3);

      sendKey(1'b1, 1'b1, 8'h75);
      step(1);
      checkOutput("kbd up after 1", 32'(ctrl_n[3]), 32'h1);
      step(1);
      checkOutput("kbd up after 2", 32'(ctrl_n[3]), 32'h0);
      sendKey(1'b0, 1'b1, 8'h75);
      step(2);
      checkOutput("kbd up release", 32'(ctrl_n[3]), 32'h1);

      sendKey(1'b1, 1'b0, 8'h75);
      step(2);
      checkOutput("non-ext 75 ignored", 32'(ctrl_n), 32'h0FFF);
      sendKey(1'b1, 1'b0, 8'h2D);
      step(2);
      checkOutput("p1 up key", 32'(ctrl_n), 32'h0DFF);
      sendKey(1'b0, 1'b0, 8'h2D);
      step(2);

      joy_in[1:0] = 2'b11;
      step(1);
      checkOutput("socd L+R", 32'(ctrl_n[1:0]), 32'h3);
      joy_in[0] = 1'b0;
      step(1);
      checkOutput("socd L only", 32'(ctrl_n[1:0]), 32'h1);
      joy_in[1] = 1'b0;

      joy_in[4] = 1'b1;
      autofire_en[0] = 1'b1;
      step(1);
      for (int i = 0; i < 16; i++) begin
         s[i] = ctrl_n[4];
         step(1);
      end
      altOk = 1'b1;
      trans = 0;
      for (int i = 0; i < 12; i++) if (s[i] == s[i+4]) altOk = 1'b0;
      for (int i = 0; i < 15; i++) if (s[i] != s[i+1]) trans++;
      checkOutput("autofire half-period", 32'(altOk), 32'h1);
      checkOutput("autofire run length", 32'(trans <= 4), 32'h1);
      autofire_en[0] = 1'b0;
      step(1);
      allLow = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (ctrl_n[4] != 1'b0) allLow = 1'b0;
         step(1);
      end
      checkOutput("autofire off steady", 32'(allLow), 32'h1);
      joy_in[4] = 1'b0;
      step(2);

      l0 = coinLows; f0 = coinFalls;
      sendKey(1'b1, 1'b0, 8'h04);
      step(20);
      sendKey(1'b0, 1'b0, 8'h04);
      step(12);
      checkOutput("coin held lows", 32'(coinLows - l0), 32'd8);
      checkOutput("coin held pulses", 32'(coinFalls - f0), 32'd1);

      l0 = coinLows; f0 = coinFalls;
      sendKey(1'b1, 1'b0, 8'h04);
      step(3);
      sendKey(1'b0, 1'b0, 8'h04);
      step(2);
      sendKey(1'b1, 1'b0, 8'h04);
      step(2);
      sendKey(1'b0, 1'b0, 8'h04);
      step(12);
      checkOutput("coin retrigger lows", 32'(coinLows - l0), 32'd8);
      checkOutput("coin retrigger pulses", 32'(coinFalls - f0), 32'd1);

      l0 = coinLows; f0 = coinFalls;
      sendKey(1'b1, 1'b0, 8'h04);
      step(15);
      sendKey(1'b0, 1'b0, 8'h04);
      step(3);
      checkOutput("coin rearm lows", 32'(coinLows - l0), 32'd8);
      checkOutput("coin rearm pulses", 32'(coinFalls - f0), 32'd1);

      sendKey(1'b1, 1'b0, 8'h04);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1);
         if (coin_n[0] == 1'b0) found = 1'b1;
      end
      checkOutput("coin pulse started", 32'(found), 32'h1);
      step(2);
      #2 rst = 1'b1;
      #1 checkOutput("async rst coin_n", 32'(coin_n[0]), 32'h1);
      ps2_key  = '0;
      txToggle = 1'b0;
      step(2);
      rst = 1'b0;
      l0 = coinLows;
      step(12);
      checkOutput("latch cleared by rst", 32'(coinLows - l0), 32'd0);

      sendKey(1'b1, 1'b1, 8'h75);
      step(2);
      checkOutput("held before clear", 32'(ctrl_n[3]), 32'h0);
      key_clear = 1'b1;
      step(1);
      key_clear = 1'b0;
      step(1);
      checkOutput("key_clear releases", 32'(ctrl_n[3]), 32'h1);
      key_clear = 1'b1;
      sendKey(1'b1, 1'b1, 8'h72);
      step(1);
      key_clear = 1'b0;
      step(1);
      checkOutput("clear beats event", 32'(ctrl_n[2]), 32'h1);
      step(2);
      checkOutput("no late event", 32'(ctrl_n[2]), 32'h1);

      for (int i = 0; i < 3000; i++) begin
         applyStimulus();
         if ($urandom_range(0, 599) == 0) begin
            #2 rst = 1'b1;
            step(1);
            rst = 1'b0;
         end else begin
            step(1);
         end
      end
      key_clear = 1'b0;
      step(2);
      checking = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
- Parametrised successor to the per-core keyboard/joystick merge logic.
- Decodes MiSTer `ps2_key` events into latched key states for up to two keyboard players, and merges them with N joystick players.
- Applies SOCD cleaning, per-button autofire and fixed-width coin pulses.
- Drives active-low control buses straight into the game core's joystick/start/coin inputs.

Parameters:
NUM_PLAYERS, 2, players (1..4); only players 0 and 1 have keyboard maps
NUM_BTN, 2, action buttons per player (1..4)
COIN_PULSE, 16, coin_n low width in clk cycles (>=1)
AUTOFIRE_DIV, 65536, clk cycles per autofire phase half-period (>=2)
SOCD_NEUTRAL, 1, 1 = opposing directions both released; 0 = pass both through

Ports:
clk  in  1  system clock
rst  in  1  reset
ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode
key_clear  in  1  synchronous clear of all keyboard latches (focus loss)
joy_in  in  NUM_PLAYERS*(6+NUM_BTN)  per player, active-high: [0]R [1]L [2]D [3]U [4+k] btn k, [4+NUM_BTN] start, [5+NUM_BTN] coin
autofire_en  in  NUM_PLAYERS*NUM_BTN  per-button autofire enable
ctrl_n  out  NUM_PLAYERS*(4+NUM_BTN)  active-low, per player [0]R [1]L [2]D [3]U [4+k] btn k
start_n  out  NUM_PLAYERS  active-low start
coin_n  out  NUM_PLAYERS  active-low coin pulse

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset state:
  - All key latches 0; coin counters 0; autofire divider and phase 0.
  - Registered `ps2_key[10]` copy loads 0.
  - ctrl_n, start_n and coin_n all ones.
- Key event detection:
  - Event when `ps2_key[10]` differs from its registered copy.
  - Lookup on {extended, scancode} against the package map; the matching latch loads `pressed`.
  - Unmapped codes are ignored.
  - Codes mapped to a player index >= NUM_PLAYERS, or a button index >= NUM_BTN, are ignored.
- key_clear:
  - Zeroes all key latches.
  - If an event arrives in the same cycle, key_clear wins.
- Merge: per signal, `req = key_latch | joy_in`.
- SOCD (SOCD_NEUTRAL=1):
  - L&R both requested -> both released.
  - U&D both requested -> both released.
  - Axes are independent.
- Autofire:
  - A single free-running counter counts 0..AUTOFIRE_DIV-1; phase toggles on wrap.
  - For a button with autofire_en=1: output asserted = req & phase.
  - Otherwise: asserted = req.
  - Deasserting autofire_en takes effect next cycle.
- Coin, per player:
  - The rising edge of merged coin req starts a counter.
  - coin_n is low for exactly COIN_PULSE cycles.
  - Edges during an active pulse are ignored.
  - Holding coin longer than the pulse yields one pulse only; re-arm requires req to fall first.
- Start: level path, no stretching.
- Latency, all outputs registered:
  - joy_in -> ctrl_n/start_n: 1 cycle.
  - ps2 toggle -> ctrl_n: 2 cycles.
  - joy coin rise -> coin_n low: 1 cycle; keyboard coin: 2 cycles.
- Async rst mid-pulse aborts the pulse immediately; coin_n returns to 1.

Decomposition:
- Package `arcade_input_pkg`:
  - Key-map typedef {valid, player, kind (dir/btn/start/coin), index}.
  - Constant lookup function on {ext, code}.
  - Joystick bit-offset localparams.
  - Map contents:
    - P0: E0-75 U, E0-72 D, E0-6B L, E0-74 R, 14 btn0, 29 btn1, 12 btn2, 1A btn3.
    - P1: 2D U, 2B D, 23 L, 34 R, 1C btn0, 1B btn1, 15 btn2, 1D btn3.
    - F1 (05) start0, F2 (06) start1, F3 (04) coin0, F4 (0C) coin1.
- Sub-module `coin_pulser`: edge detect plus counter, one instance per player.

Test Plan:
All scenarios use NUM_PLAYERS=2, NUM_BTN=2, COIN_PULSE=8, AUTOFIRE_DIV=4.
- Reset release -> ctrl_n=12'hFFF, start_n=2'b11, coin_n=2'b11. Toggle ps2_key to {1,1,1,8'h75} -> ctrl_n[3]=0 two cycles later. Release event -> ctrl_n[3]=1.
- Non-extended 0x75 press -> no output change. 0x2D press -> player 1 bit [3] low; player 0 unaffected.
- joy_in P0 L=1 and R=1 -> ctrl_n[1:0]=2'b11. Drop R -> ctrl_n[1:0]=2'b01 next cycle.
- Hold P0 btn0 with autofire_en[0]=1 -> ctrl_n[4] alternates 4 cycles low / 4 cycles high. autofire_en=0 -> steady low.
- Press F3 for 20 cycles -> coin_n[0] low exactly 8 cycles, one pulse. Second press during the pulse -> no extension. Press again after release -> new 8-cycle pulse.
- Assert rst at cycle 3 of a coin pulse -> coin_n[0]=1 asynchronously and latches clear. key_clear while a key is held -> that output deasserts next cycle.
